// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-wide memory controller: request opcodes, access sizes,
// extension modes, FSM states and the beat-count helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpRead  = 2'b01,
        OpWrite = 2'b10
    } me_op_e;

    localparam logic [1:0] SelNone = 2'b00;
    localparam logic [1:0] SelByte = 2'b01;
    localparam logic [1:0] SelHalf = 2'b10;
    localparam logic [1:0] SelWord = 2'b11;

    localparam logic SEXT = 1'b0;
    localparam logic UEXT = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StIfRd,
        StMemRd,
        StMemWr,
        StDone
    } state_e;

    function automatic logic [2:0] sel_beats(input logic [1:0] sel);
        case (sel)
            SelByte: return 3'd1;
            SelHalf: return 3'd2;
            SelWord: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_extend.sv
// Combinational byte/half/word sign or zero extender for load results.
module mem_extend
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  sel_i,
    input  logic        ext_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (sel_i)
            SelByte: data_o = (ext_i == UEXT) ? {24'd0, data_i[7:0]}
                                              : {{24{data_i[7]}}, data_i[7:0]};
            SelHalf: data_o = (ext_i == UEXT) ? {16'd0, data_i[15:0]}
                                              : {{16{data_i[15]}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Shares one byte-wide synchronous RAM between instruction fetch and the MEM stage.
// Define MEM_CTRL_PREFETCH_EN to add a one-entry next-instruction prefetch buffer.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned RAM_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_done,
    output logic [31:0]           if_inst,
    input  logic [1:0]            me_op,
    input  logic [ADDR_W-1:0]     me_addr,
    input  logic [31:0]           me_data,
    input  logic [1:0]            me_sel,
    input  logic                  me_extend,
    output logic                  me_done,
    output logic [31:0]           me_rdata,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d, beats_q, beats_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d, buf_q, buf_d;
    logic [1:0]            sel_q, sel_d;
    logic                  ext_q, ext_d;
    logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_wr_q, ram_wr_d, if_done_q, if_done_d, me_done_q, me_done_d;
    logic [7:0]            ram_dout_q, ram_dout_d;
    logic [31:0]           if_inst_q, if_inst_d, me_rdata_q, me_rdata_d;
    logic                  busy_q, busy_d;
`ifdef MEM_CTRL_PREFETCH_EN
    logic [ADDR_W-1:0]     pf_addr_q, pf_addr_d, pf_next_q, pf_next_d;
    logic [31:0]           pf_data_q, pf_data_d;
    logic                  pf_valid_q, pf_valid_d, pf_pend_q, pf_pend_d;
    logic                  is_pf_q, is_pf_d, hit_q, hit_d;
`endif

    logic                  me_req, start_fetch;
    logic [ADDR_W-1:0]     fetch_addr;
    logic [2:0]            cnt_inc;
    logic [1:0]            cap_idx, wr_idx;
    logic [RAM_ADDR_W-1:0] beat_addr;
    logic [31:0]           merged, ext_data;
    logic [7:0]            wbyte;
    logic                  unused_addr_hi;

    assign me_req    = (me_op == OpRead || me_op == OpWrite) && me_sel != SelNone;
    assign cnt_inc   = cnt_q + 3'd1;
    assign cap_idx   = cnt_q[1:0] - 2'd1;
    assign wr_idx    = cnt_inc[1:0];
    // RAM_ADDR_W-wide add so the beat address wraps at the top of the RAM.
    assign beat_addr = addr_q[RAM_ADDR_W-1:0] + RAM_ADDR_W'(cnt_inc);
    assign wbyte     = wdata_q[{wr_idx, 3'b000} +: 8];
    assign unused_addr_hi = ^addr_q[ADDR_W-1:RAM_ADDR_W];

    // Byte returned this cycle belongs to the address driven in the previous cycle.
    always_comb begin
        merged = buf_q;
        merged[{cap_idx, 3'b000} +: 8] = ram_din;
    end

    mem_extend u_mem_extend (
        .data_i (merged),
        .sel_i  (sel_q),
        .ext_i  (ext_q),
        .data_o (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beats_d     = beats_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        ext_d       = ext_q;
        buf_d       = buf_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_done_d   = 1'b0;
        me_done_d   = 1'b0;
        if_inst_d   = if_inst_q;
        me_rdata_d  = me_rdata_q;
        start_fetch = 1'b0;
        fetch_addr  = if_addr;
`ifdef MEM_CTRL_PREFETCH_EN
        pf_addr_d   = pf_addr_q;
        pf_next_d   = pf_next_q;
        pf_data_d   = pf_data_q;
        pf_valid_d  = pf_valid_q;
        pf_pend_d   = pf_pend_q;
        is_pf_d     = is_pf_q;
        hit_d       = hit_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = 3'd0;
                buf_d = 32'd0;
                if (me_req) begin
                    addr_d     = me_addr;
                    wdata_d    = me_data;
                    sel_d      = me_sel;
                    ext_d      = me_extend;
                    beats_d    = sel_beats(me_sel);
                    ram_addr_d = me_addr[RAM_ADDR_W-1:0];
                    if (me_op == OpWrite) begin
                        state_d    = StMemWr;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = me_data[7:0];
`ifdef MEM_CTRL_PREFETCH_EN
                        pf_valid_d = 1'b0;
                        pf_pend_d  = 1'b0;
`endif
                    end else begin
                        state_d = StMemRd;
                    end
                end else if (if_req) begin
`ifdef MEM_CTRL_PREFETCH_EN
                    if (pf_valid_q && if_addr == pf_addr_q) begin
                        state_d   = StDone;
                        hit_d     = 1'b1;
                        pf_pend_d = 1'b1;
                        pf_next_d = if_addr + ADDR_W'(4);
                    end else begin
                        start_fetch = 1'b1;
                        is_pf_d     = 1'b0;
                    end
`else
                    start_fetch = 1'b1;
`endif
                end
`ifdef MEM_CTRL_PREFETCH_EN
                else if (pf_pend_q) begin
                    start_fetch = 1'b1;
                    fetch_addr  = pf_next_q;
                    is_pf_d     = 1'b1;
                    pf_pend_d   = 1'b0;
                end
`endif
                if (start_fetch) begin
                    state_d    = StIfRd;
                    addr_d     = fetch_addr;
                    sel_d      = SelWord;
                    ext_d      = UEXT;
                    beats_d    = 3'd4;
                    ram_addr_d = fetch_addr[RAM_ADDR_W-1:0];
                end
            end
            StIfRd, StMemRd: begin
                cnt_d = cnt_inc;
                if (cnt_inc < beats_q) ram_addr_d = beat_addr;
                if (cnt_q != 3'd0) buf_d = merged;
                if (cnt_q == beats_q) begin
                    if (state_q == StMemRd) begin
                        state_d    = StDone;
                        me_done_d  = 1'b1;
                        me_rdata_d = ext_data;
                    end
`ifdef MEM_CTRL_PREFETCH_EN
                    else if (is_pf_q) begin
                        state_d    = StIdle;
                        pf_valid_d = 1'b1;
                        pf_addr_d  = addr_q;
                        pf_data_d  = merged;
                    end
`endif
                    else begin
                        state_d   = StDone;
                        if_done_d = 1'b1;
                        if_inst_d = merged;
`ifdef MEM_CTRL_PREFETCH_EN
                        pf_pend_d = 1'b1;
                        pf_next_d = addr_q + ADDR_W'(4);
`endif
                    end
                end
            end
            StMemWr: begin
                cnt_d = cnt_inc;
                if (cnt_inc < beats_q) begin
                    ram_wr_d   = 1'b1;
                    ram_addr_d = beat_addr;
                    ram_dout_d = wbyte;
                end else begin
                    state_d   = StDone;
                    me_done_d = 1'b1;
                end
            end
            StDone: begin
`ifdef MEM_CTRL_PREFETCH_EN
                // A buffer hit spends one extra DONE cycle so the pulse is registered.
                if (hit_q) begin
                    hit_d     = 1'b0;
                    if_done_d = 1'b1;
                    if_inst_d = pf_data_q;
                end else begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            beats_q    <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            buf_q      <= 32'd0;
            sel_q      <= SelNone;
            ext_q      <= SEXT;
            ram_addr_q <= '0;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= 8'd0;
            if_done_q  <= 1'b0;
            me_done_q  <= 1'b0;
            if_inst_q  <= 32'd0;
            me_rdata_q <= 32'd0;
            busy_q     <= 1'b0;
`ifdef MEM_CTRL_PREFETCH_EN
            pf_addr_q  <= '0;
            pf_next_q  <= '0;
            pf_data_q  <= 32'd0;
            pf_valid_q <= 1'b0;
            pf_pend_q  <= 1'b0;
            is_pf_q    <= 1'b0;
            hit_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beats_q    <= beats_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            sel_q      <= sel_d;
            ext_q      <= ext_d;
            ram_addr_q <= ram_addr_d;
            ram_wr_q   <= ram_wr_d;
            ram_dout_q <= ram_dout_d;
            if_done_q  <= if_done_d;
            me_done_q  <= me_done_d;
            if_inst_q  <= if_inst_d;
            me_rdata_q <= me_rdata_d;
            busy_q     <= busy_d;
`ifdef MEM_CTRL_PREFETCH_EN
            pf_addr_q  <= pf_addr_d;
            pf_next_q  <= pf_next_d;
            pf_data_q  <= pf_data_d;
            pf_valid_q <= pf_valid_d;
            pf_pend_q  <= pf_pend_d;
            is_pf_q    <= is_pf_d;
            hit_q      <= hit_d;
`endif
        end
    end

    assign if_done  = if_done_q;
    assign if_inst  = if_inst_q;
    assign me_done  = me_done_q;
    assign me_rdata = me_rdata_q;
    assign ram_addr = ram_addr_q;
    assign ram_wr   = ram_wr_q;
    assign ram_dout = ram_dout_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a behavioural byte RAM; prefetch cases are
// compiled in only when MEM_CTRL_PREFETCH_EN is defined.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned RAM_ADDR_W = 17;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  if_req = 1'b0;
    logic [ADDR_W-1:0]     if_addr = '0;
    logic                  if_done;
    logic [31:0]           if_inst;
    logic [1:0]            me_op = 2'b00;
    logic [ADDR_W-1:0]     me_addr = '0;
    logic [31:0]           me_data = '0;
    logic [1:0]            me_sel = 2'b00;
    logic                  me_extend = 1'b0;
    logic                  me_done;
    logic [31:0]           me_rdata;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  ram_wr;
    logic [7:0]            ram_dout;
    logic [7:0]            ram_din;
    logic                  busy;

    mem_ctrl #(
        .ADDR_W     (ADDR_W),
        .RAM_ADDR_W (RAM_ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_inst   (if_inst),
        .me_op     (me_op),
        .me_addr   (me_addr),
        .me_data   (me_data),
        .me_sel    (me_sel),
        .me_extend (me_extend),
        .me_done   (me_done),
        .me_rdata  (me_rdata),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write on the edge, read data one cycle after its address.
    logic [7:0]            ram [0:(1<<RAM_ADDR_W)-1];
    logic                  poke_en = 1'b0;
    logic [RAM_ADDR_W-1:0] poke_addr = '0;
    logic [7:0]            poke_data = '0;
    always @(posedge clk) begin
        if (poke_en) ram[poke_addr] <= poke_data;
        else if (ram_wr) ram[ram_addr] <= ram_dout;
        ram_din <= ram[ram_addr];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          is_if;
        bit          chk;
        logic [31:0] data;
        int unsigned cyc;
        string       tag;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Expected done cycle = drive-time count + accept edge + latency.
    task automatic push_exp(input bit is_if, input bit chk, input logic [31:0] data,
                            input int unsigned lat, input string tag);
        exp_t e;
        e.is_if = is_if;
        e.chk   = chk;
        e.data  = data;
        e.cyc   = cyc + 1 + lat;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (if_done || me_done)) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", {30'd0, if_done, me_done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq({mon_e.tag, "_which"}, {30'd0, if_done, me_done},
                         mon_e.is_if ? 32'd2 : 32'd1);
                check_eq({mon_e.tag, "_cycle"}, cyc, mon_e.cyc);
                if (mon_e.chk)
                    check_eq({mon_e.tag, "_data"}, mon_e.is_if ? if_inst : me_rdata, mon_e.data);
            end
        end
    end

    task automatic poke(input logic [RAM_ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic poke_word(input logic [RAM_ADDR_W-1:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) poke(a + RAM_ADDR_W'(i), w[8*i +: 8]);
    endtask

    task automatic wait_idle();
        int run = 0;
        for (int i = 0; i < 200 && run < 2; i++) begin
            @(negedge clk);
            run = busy ? 0 : run + 1;
        end
        if (run < 2) check_eq("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_sb(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check_eq({tag, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic mem_txn(input string tag, input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] sel, input logic ext,
                           input logic [31:0] exp_data, input int unsigned lat);
        wait_idle();
        me_op = op; me_addr = addr; me_data = data; me_sel = sel; me_extend = ext;
        push_exp(1'b0, op == OpRead, exp_data, lat, tag);
        @(negedge clk);
        // Scramble the request after acceptance; the latched copy must be used.
        me_op = 2'b00; me_sel = 2'b00; me_addr = $urandom; me_data = $urandom;
        me_extend = ~ext;
        wait_sb(tag);
    endtask

    task automatic if_txn(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input int unsigned lat);
        wait_idle();
        if_req = 1'b1; if_addr = addr;
        push_exp(1'b1, 1'b1, exp_data, lat, tag);
        @(negedge clk);
        if_req = 1'b0; if_addr = $urandom;
        wait_sb(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        poke_word(17'h00100, 32'h0000_0513);
        poke_word(17'h00104, 32'h0000_00C3);
        poke(17'h00020, 8'h80);
        poke_word(17'h00030, 32'h0000_A534);
        poke_word(17'h00040, 32'h5A33_2211);
        poke_word(17'h00080, 32'hAAAA_AAAA);
        poke(17'h1FFFF, 8'h11);
        poke_word(17'h00000, 32'h5544_3322);
        poke_word(17'h00004, 32'h0403_0201);
        poke_word(17'h00010, 32'h7654_3210);
        poke_word(17'h00014, 32'hF0DE_BC9A);

        @(negedge clk);
        check_eq("rst_done", {30'd0, if_done, me_done}, 32'd0);
        check_eq("rst_if_inst", if_inst, 32'd0);
        check_eq("rst_me_rdata", me_rdata, 32'd0);
        check_eq("rst_ram", {6'd0, ram_wr, busy, ram_dout, 7'd0, ram_addr}, 32'd0);
        rst = 1'b0;

        // Instruction fetch with per-beat address check.
        wait_idle();
        if_req = 1'b1; if_addr = 32'h100;
        push_exp(1'b1, 1'b1, 32'h0000_0513, 5, "if_fetch");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if_req = 1'b0;
            check_eq($sformatf("if_ram_addr%0d", k), {15'd0, ram_addr}, 32'h100 + k);
        end
        wait_sb("if_fetch");

        mem_txn("lb",  OpRead, 32'h20, 32'h0, SelByte, SEXT, 32'hFFFF_FF80, 2);
        mem_txn("lbu", OpRead, 32'h20, 32'h0, SelByte, UEXT, 32'h0000_0080, 2);
        mem_txn("lh",  OpRead, 32'h30, 32'h0, SelHalf, SEXT, 32'hFFFF_A534, 3);
        mem_txn("lhu", OpRead, 32'h30, 32'h0, SelHalf, UEXT, 32'h0000_A534, 3);
        mem_txn("lw_misal", OpRead, 32'h101, 32'h0, SelWord, SEXT, 32'hC300_0005, 5);
        mem_txn("lw_wrap", OpRead, 32'hABC1_FFFF, 32'h0, SelWord, SEXT, 32'h4433_2211, 5);

        // Misaligned halfword store with per-beat RAM port checks.
        wait_idle();
        me_op = OpWrite; me_addr = 32'h41; me_data = 32'hDEAD_BEEF; me_sel = SelHalf;
        push_exp(1'b0, 1'b0, 32'h0, 2, "sh");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            me_op = 2'b00; me_sel = 2'b00; me_data = $urandom;
            check_eq($sformatf("sh_beat%0d", k), {ram_wr, 6'd0, ram_addr, ram_dout},
                     {1'b1, 6'd0, 17'h41 + 17'(k), k == 0 ? 8'hEF : 8'hBE});
        end
        @(negedge clk);
        check_eq("sh_wr_done", {31'd0, ram_wr}, 32'd0);
        wait_sb("sh");
        check_eq("sh_ram", {ram[17'h41], ram[17'h42], ram[17'h43]}, 32'h00EF_BE5A);
        mem_txn("lw_after_sh", OpRead, 32'h40, 32'h0, SelWord, UEXT, 32'h5ABE_EF11, 5);

        mem_txn("sw", OpWrite, 32'h200, 32'hCAFE_F00D, SelWord, SEXT, 32'h0, 4);
        mem_txn("lw_sw", OpRead, 32'h200, 32'h0, SelWord, SEXT, 32'hCAFE_F00D, 5);
        mem_txn("sb", OpWrite, 32'h203, 32'h1234_5677, SelByte, SEXT, 32'h0, 1);
        mem_txn("lw_sb", OpRead, 32'h200, 32'h0, SelWord, SEXT, 32'h77FE_F00D, 5);

        // Simultaneous MEM and IF requests: MEM first, IF waits through DONE.
        wait_idle();
        me_op = OpRead; me_addr = 32'h100; me_sel = SelWord; me_extend = UEXT;
        if_req = 1'b1; if_addr = 32'h104;
        push_exp(1'b0, 1'b1, 32'h0000_0513, 5, "b2b_lw");
        push_exp(1'b1, 1'b1, 32'h0000_00C3, 12, "b2b_if");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            me_op = 2'b00; me_sel = 2'b00;
            if (k == 6) check_eq("b2b_gap_busy", {31'd0, busy}, 32'd0);
        end
        if_req = 1'b0;
        wait_sb("b2b");

        // Reset two beats into a word store.
        wait_idle();
        me_op = OpWrite; me_addr = 32'h80; me_data = 32'h1122_3344; me_sel = SelWord;
        @(negedge clk);
        me_op = 2'b00; me_sel = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_state", {29'd0, ram_wr, busy, me_done}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("rst_mid_ram", {ram[17'h80], ram[17'h81], ram[17'h82], ram[17'h83]},
                 32'h4433_AAAA);
        check_eq("rst_mid_rdata", me_rdata, 32'd0);

`ifdef MEM_CTRL_PREFETCH_EN
        if_txn("pf_first", 32'h0, 32'h5544_3322, 5);
        if_txn("pf_hit", 32'h4, 32'h0403_0201, 1);
        if_txn("pf_miss_a", 32'h10, 32'h7654_3210, 5);
        mem_txn("pf_sb", OpWrite, 32'h300, 32'h0000_0055, SelByte, SEXT, 32'h0, 1);
        if_txn("pf_miss_b", 32'h14, 32'hF0DE_BC9A, 5);
`else
        if_txn("if_plain", 32'h4, 32'h0403_0201, 5);
`endif

        wait_idle();
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
